// File: rtl/irq_receiver.sv
// irq_receiver: synchronises and edge-detects interrupt request lines into sticky pending bits,
// then drives one priority-resolved IRQ to the CPU with an ack/vector/EOI handshake.
// Optional lost-edge counter (miss_count, miss_clr) is enabled by defining IRQ_MISS_CNT_EN.
module irq_receiver #(
  parameter int NUM_SRC     = 4,
  parameter int VEC_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
`ifdef IRQ_MISS_CNT_EN
  input  logic               miss_clr,
  output logic [7:0]         miss_count,
`endif
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq,
  input  logic               irq_ack,
  output logic               vec_valid,
  output logic [VEC_W-1:0]   vec,
  input  logic               eoi,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                                 state_reg;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]    sync_reg;
  logic [NUM_SRC-1:0]                     prev_reg;
  logic [NUM_SRC-1:0]                     pending_reg;
  logic [NUM_SRC-1:0]                     pending_next;
  logic [NUM_SRC-1:0]                     mask_reg;
  logic [NUM_SRC-1:0]                     rise;
  logic [NUM_SRC-1:0]                     work;
  logic [NUM_SRC-1:0]                     clr;
  logic [VEC_W-1:0]                       sel;
  logic                                   take;
  logic                                   irq_reg;
  logic                                   vec_valid_reg;
  logic [VEC_W-1:0]                       vec_reg;
  logic                                   in_service_reg;

  // Stage 0 samples the raw line; the last stage feeds the edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign work = pending_reg & mask_reg;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (work[i]) sel = i[VEC_W-1:0];
    end
  end

  // Selection uses the mask in force this cycle, so a simultaneous mask write cannot steer it.
  assign take = (state_reg == REQ) && irq_ack && (|work);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
    assign clr[gi] = take && (sel == VEC_W'(gi));
  end

  // A fresh edge wins over the ack clear of the same bit.
  assign pending_next = (pending_reg & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (mask_wr) mask_reg <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      irq_reg        <= 1'b0;
      vec_valid_reg  <= 1'b0;
      vec_reg        <= '0;
      in_service_reg <= 1'b0;
    end else begin
      vec_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|work) begin
            state_reg <= REQ;
            irq_reg   <= 1'b1;
          end
        end
        REQ: begin
          if (!(|work)) begin
            state_reg <= IDLE;
            irq_reg   <= 1'b0;
          end else if (irq_ack) begin
            state_reg      <= SERVICE;
            irq_reg        <= 1'b0;
            vec_reg        <= sel;
            vec_valid_reg  <= 1'b1;
            in_service_reg <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_reg      <= IDLE;
            in_service_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          irq_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_MISS_CNT_EN
  localparam int CNT_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0] lost;
  logic [CNT_W-1:0]   lost_cnt;
  logic [8:0]         miss_sum;
  logic [7:0]         miss_reg;

  // An edge is lost only if its pending bit stays set without being consumed this cycle.
  assign lost = rise & pending_reg & ~clr;

  always_comb begin
    lost_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lost_cnt = lost_cnt + CNT_W'(lost[i]);
    end
  end

  assign miss_sum = {1'b0, miss_reg} + 9'(lost_cnt);

  always_ff @(posedge clk) begin
    if (reset || miss_clr) begin
      miss_reg <= '0;
    end else if (miss_sum > 9'd255) begin
      miss_reg <= 8'd255;
    end else begin
      miss_reg <= miss_sum[7:0];
    end
  end

  assign miss_count = miss_reg;
`endif

  assign mask       = mask_reg;
  assign pending    = pending_reg;
  assign irq        = irq_reg;
  assign vec_valid  = vec_valid_reg;
  assign vec        = vec_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_receiver.sv
// tb_irq_receiver: directed and randomized stimulus against a set-based pending model;
// expected vectors are queued at ack time and popped by a monitor on every vec_valid pulse.
module tb_irq_receiver;

  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               irq;
  logic               irq_ack;
  logic               vec_valid;
  logic [VEC_W-1:0]   vec;
  logic               eoi;
  logic               in_service;
`ifdef IRQ_MISS_CNT_EN
  logic               miss_clr;
  logic [7:0]         miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int sb[$];

  always #5 clk = ~clk;

  irq_receiver #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
`ifdef IRQ_MISS_CNT_EN
    .miss_clr(miss_clr),
    .miss_count(miss_count),
`endif
    .irq_in(irq_in),
    .mask_wr(mask_wr),
    .mask_wdata(mask_wdata),
    .mask(mask),
    .pending(pending),
    .irq(irq),
    .irq_ack(irq_ack),
    .vec_valid(vec_valid),
    .vec(vec),
    .eoi(eoi),
    .in_service(in_service)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Highest priority enabled source: lowest set index.
  function automatic int lowest(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_irq(input string name, input int max);
    for (int i = 0; i < max && irq !== 1'b1; i++) cyc(1);
    check(name, irq, 1);
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_wr = 1'b1; mask_wdata = m;
    cyc(1);
    mask_wr = 1'b0;
  endtask

  task automatic do_ack(input int exp_vec);
    sb.push_back(exp_vec);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    mask_wr = 1'b0;
    check("ack_vec_valid", vec_valid, 1);
    check("ack_irq_low", irq, 0);
    check("ack_in_service", in_service, 1);
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    cyc(1);
    eoi = 1'b0;
    check("eoi_in_service", in_service, 0);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] lines, input int len);
    irq_in = lines;
    cyc(len);
    irq_in = '0;
  endtask

  // Scoreboard monitor: every vec_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (vec_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL vec_unexpected: got vec_valid=1 vec=%0d required no pulse", vec);
      end else begin
        check("vec", 32'(vec), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_SRC-1:0] model_pend;
    logic [NUM_SRC-1:0] model_mask;
    logic [NUM_SRC-1:0] lines;
    reset = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;
`ifdef IRQ_MISS_CNT_EN
    miss_clr = 1'b0;
`endif
    cyc(3);
    check("rst_mask", mask, 0);
    check("rst_pending", pending, 0);
    check("rst_irq", irq, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_vec", vec, 0);
    check("rst_in_service", in_service, 0);
    reset = 1'b0;
    cyc(1);

    // Single 3-cycle pulse on line 2.
    write_mask(4'b1111);
    check("mask_f", mask, 4'b1111);
    irq_in[2] = 1'b1;
    cyc(3);
    irq_in = '0;
    check("t1_pending", pending, 4'b0100);
    check("t1_irq_not_yet", irq, 0);
    cyc(1);
    check("t1_irq", irq, 1);
    do_ack(2);
    check("t1_pending_clr", pending, 0);
    do_eoi();
    cyc(2);
    check("t1_irq_stays_low", irq, 0);

    // Simultaneous pulses on lines 3 and 1: priority order.
    pulse(4'b1010, 2);
    wait_irq("t2_irq1", 6);
    do_ack(1);
    check("t2_pending", pending, 4'b1000);
    do_eoi();
    wait_irq("t2_irq2", 4);
    do_ack(3);
    check("t2_pending_empty", pending, 0);
    do_eoi();

    // Masked source stays pending; unmasking raises irq.
    write_mask(4'b0000);
    pulse(4'b0001, 1);
    cyc(5);
    check("t3_pending", pending, 4'b0001);
    check("t3_irq_masked", irq, 0);
    write_mask(4'b0001);
    cyc(1);
    check("t3_irq_unmasked", irq, 1);
    do_ack(0);
    do_eoi();

    // Held-high line gives exactly one event; ack in IDLE is ignored.
    write_mask(4'b1111);
    irq_in[1] = 1'b1;
    wait_irq("t4_irq", 6);
    do_ack(1);
    do_eoi();
    cyc(14);
    irq_in = '0;
    cyc(5);
    check("t4_pending", pending, 0);
    check("t4_irq", irq, 0);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("t4_idle_ack_vv", vec_valid, 0);
    check("t4_idle_ack_ins", in_service, 0);

    // Mask write coincident with ack: old mask selects.
    pulse(4'b0100, 1);
    wait_irq("t5_irq", 6);
    mask_wr = 1'b1; mask_wdata = 4'b0000;
    do_ack(2);
    check("t5_mask_new", mask, 0);
    do_eoi();
    write_mask(4'b1111);

    // New edge on the selected source in its ack cycle: the set wins.
    pulse(4'b0010, 1);
    wait_irq("t6_irq", 6);
    irq_in[1] = 1'b1;
    cyc(2);
    do_ack(1);
    irq_in = '0;
    check("t6_set_wins", pending, 4'b0010);
    do_eoi();
    wait_irq("t6_irq_again", 4);
    do_ack(1);
    do_eoi();

    // Reset while in REQ.
    pulse(4'b0001, 1);
    wait_irq("t7_irq", 6);
    reset = 1'b1;
    cyc(1);
    check("t7_irq", irq, 0);
    check("t7_pending", pending, 0);
    check("t7_mask", mask, 0);
    check("t7_in_service", in_service, 0);
    reset = 1'b0;
    cyc(5);
    check("t7_pending_after", pending, 0);

    // Randomized phase against a set-based model.
    model_mask = 4'b1111;
    model_pend = '0;
    write_mask(model_mask);
    for (int it = 0; it < 40; it++) begin
      lines = NUM_SRC'($urandom_range(0, 15));
      pulse(lines, $urandom_range(1, 4));
      cyc(4);
      model_pend = model_pend | lines;
      if ($urandom_range(0, 3) == 0) begin
        model_mask = NUM_SRC'($urandom_range(0, 15));
        write_mask(model_mask);
      end
      check("rnd_pending", pending, model_pend);
      if ((model_pend & model_mask) != '0) begin
        wait_irq("rnd_irq", 4);
        do_ack(lowest(model_pend & model_mask));
        model_pend[lowest(model_pend & model_mask)] = 1'b0;
        check("rnd_pending_ack", pending, model_pend);
        cyc($urandom_range(0, 3));
        do_eoi();
      end else begin
        cyc(2);
        check("rnd_irq_low", irq, 0);
      end
    end

`ifdef IRQ_MISS_CNT_EN
    write_mask(4'b0000);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("miss_rst", miss_count, 0);
    for (int p = 0; p < 300; p++) begin
      pulse(4'b0001, 1);
      cyc(3);
    end
    cyc(3);
    check("miss_sat", miss_count, 255);
    miss_clr = 1'b1;
    cyc(1);
    miss_clr = 1'b0;
    check("miss_clr", miss_count, 0);
`endif

    cyc(3);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_receiver.md
Name: irq_receiver

Overview:
- CPU-side endpoint for the multi-cycle interrupt pulses produced by the design's interrupt generators.
- Synchronises up to NUM_SRC request lines and edge-detects each into a sticky pending bit.
- Presents one masked, priority-resolved IRQ to the CPU, with an ack/vector/end-of-interrupt (EOI) handshake.
- Sits between peripheral interrupt generators and the CPU core's interrupt input.

Parameters:
- NUM_SRC, 4, number of request lines (2..16).
- VEC_W, 2, vector width; must equal $clog2(NUM_SRC).
- SYNC_STAGES, 2, synchroniser flops per line (>=2); lines may be asynchronously set at their source.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_SRC  raw request lines; event = rising edge.
- mask_wr  in  1  load mask from mask_wdata this cycle.
- mask_wdata  in  NUM_SRC  new mask; 1 = enabled.
- mask  out  NUM_SRC  current mask register.
- pending  out  NUM_SRC  sticky pending bits.
- irq  out  1  registered interrupt request to CPU.
- irq_ack  in  1  CPU accepts the interrupt (single-cycle pulse).
- vec_valid  out  1  one-cycle pulse; vec is valid.
- vec  out  VEC_W  index of the serviced source.
- eoi  in  1  CPU end-of-interrupt (single-cycle pulse).
- in_service  out  1  high while a source is being serviced.

Behaviour:
- Reset values: mask=0, pending=0, irq=0, vec_valid=0, vec=0, in_service=0. Synchroniser and edge-history flops reset to 0, FSM to IDLE.
- A line held high through reset release produces exactly one event after reset.
- Per line: SYNC_STAGES-flop synchroniser, then edge detect (sync_out & ~prev).
- An edge sets pending[i] on the next edge, SYNC_STAGES+1 clock edges after irq_in is first sampled high.
- One event per rising edge, independent of pulse length: a 3-cycle pulse and a held-high line each produce one event.
- Selection: sel = lowest index i with pending[i] & mask[i]. Index 0 has highest priority.
- FSM, 3 states, all outputs registered:
  - IDLE: if any (pending & mask), go to REQ; irq=1 from the next edge.
  - REQ: irq=1.
    - irq_ack: latch vec=sel, pulse vec_valid one cycle, clear pending[sel], irq=0, in_service=1, go to SERVICE.
    - If (pending & mask)==0 (mask write), return to IDLE with irq=0 next edge.
  - SERVICE: irq=0. On eoi: in_service=0, go to IDLE. Irq is re-raised one edge after IDLE if work remains.
- Ack-to-vec_valid latency is 1 edge. Minimum gap between back-to-back interrupts is eoi plus 2 edges.
- irq_ack outside REQ and eoi outside SERVICE are ignored, with no state change.
- A new edge on source i in the same cycle its pending bit is cleared by ack: the set wins, so pending[i] stays 1.
- A mask write in the same cycle as irq_ack: selection uses the old mask; the new mask applies next cycle.
- Masking never clears pending. Unmasking a pending source raises irq via IDLE->REQ.
- A second edge on an already-pending source is lost (pending is 1 bit).
- Sources other than sel keep their pending bits across service.
- Reset asserted in any state returns everything to reset values on that edge; vec_valid never pulses during reset.

Optional Feature:
- Macro IRQ_MISS_CNT_EN.
- When defined: adds output port miss_count (8 bits), a saturating count of edges lost because the target pending bit was already 1.
  - Several lost edges in one cycle add their total.
  - Saturates at 255; reset clears it.
  - Adds input miss_clr; the clear takes priority over increment in the same cycle.
- When undefined: no ports and no counter logic; behaviour otherwise identical.

Test Plan:
- NUM_SRC=4, SYNC_STAGES=2; mask=4'b1111, 3-cycle pulse on irq_in[2] -> pending=4'b0100 after 3 edges, irq=1 one edge later. irq_ack -> next edge vec_valid=1, vec=2, pending=0, irq=0, in_service=1. eoi -> in_service=0, irq stays 0.
- Pulses on lines 3 and 1 in the same cycle -> first ack gives vec=1, pending=4'b1000. After eoi, irq returns and the second ack gives vec=3.
- mask=4'b0000, pulse on line 0 -> pending=4'b0001, irq stays 0. Writing mask=4'b0001 -> irq=1 within 2 edges.
- Line 1 held high 20 cycles -> exactly one pending set; after ack+eoi irq stays 0. irq_ack pulsed in IDLE -> no vec_valid.
- In REQ with line 0 pending, assert reset -> all outputs 0 next edge; pending=0 after release if the line is low.
- IRQ_MISS_CNT_EN defined: 300 pulses on line 0 with no ack -> miss_count=255. miss_clr -> miss_count=0.
